// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - SRAM-like data bus between the MEM-stage access unit and memory
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
) ();
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic [31:0]       data_rdata;
    logic              data_addr_ok;
    logic              data_data_ok;

    modport master (
        output data_req,
        output data_wr,
        output data_size,
        output data_addr,
        output data_wdata,
        input  data_rdata,
        input  data_addr_ok,
        input  data_data_ok
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_addr,
        input  data_wdata,
        output data_rdata,
        output data_addr_ok,
        output data_data_ok
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store bus access unit; optional posted-store write buffer under MAU_WBUF_EN
module mem_access_unit #(
    parameter int ADDR_W     = 32,
    parameter int WBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        mem_type,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic              kill,
    input  logic              hold,
    output logic [31:0]       load_data,
    output logic              addr_err,
    output logic              stall,
    mem_access_unit_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic              req_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              zext_q;
    // own_q: transaction belongs to the instruction currently in MEM (not a buffered store)
    logic              own_q;
    // discard_q: the owning instruction was killed after issue; drop its response
    logic              discard_q;
    logic [31:0]       load_q;

    logic              is_half;
    logic              is_word;
    logic              access;
    logic              acc_valid;
    logic [1:0]        req_size;
    logic [31:0]       req_wdata;
    logic              xfer_done;
    logic              resp_take;
    logic              issue_wait;
    logic              start_own;
    logic              start_buf;
    logic              st_wr;
    logic [1:0]        st_size;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_wdata;
    logic [31:0]       rshift;
    logic [31:0]       ext_data;

    assign is_word   = mem_type[1];
    assign is_half   = (mem_type[1:0] == 2'b01);
    assign req_size  = is_word ? 2'b10 : {1'b0, mem_type[0]};
    assign access    = mem_read | mem_write;
    assign addr_err  = access & ((is_half & mem_addr[0]) |
                                 (is_word & (mem_addr[1:0] != 2'b00)));
    assign acc_valid = access & ~kill & ~addr_err;

    // Replicate store data across lanes so the slave can take whichever lane the address selects
    always_comb begin
        case (req_size)
            2'b00:   req_wdata = {4{mem_wdata[7:0]}};
            2'b01:   req_wdata = {2{mem_wdata[15:0]}};
            default: req_wdata = mem_wdata;
        endcase
    end

    assign xfer_done = (((state == REQ) & bus.data_addr_ok) | (state == RESP)) & bus.data_data_ok;
    assign resp_take = xfer_done & own_q & ~wr_q & ~discard_q & ~kill;

    // Halves are aligned, so a byte-lane shift by addr[1:0] also selects the half by addr[1]
    assign rshift = bus.data_rdata >> {addr_q[1:0], 3'b000};

    // Sign- or zero-extend the selected lane
    always_comb begin
        case (size_q)
            2'b00:   ext_data = {{24{~zext_q & rshift[7]}}, rshift[7:0]};
            2'b01:   ext_data = {{16{~zext_q & rshift[15]}}, rshift[15:0]};
            default: ext_data = bus.data_rdata;
        endcase
    end

    assign load_data = resp_take ? ext_data : load_q;

`ifdef MAU_WBUF_EN
    localparam int              PTR_W   = $clog2(WBUF_DEPTH);
    localparam logic [PTR_W:0]  WB_FULL = (PTR_W + 1)'(WBUF_DEPTH);

    logic [ADDR_W-1:0] wb_addr [WBUF_DEPTH];
    logic [1:0]        wb_size [WBUF_DEPTH];
    logic [31:0]       wb_data [WBUF_DEPTH];
    logic [PTR_W-1:0]  wb_head;
    logic [PTR_W-1:0]  wb_tail;
    logic [PTR_W:0]    wb_count;
    logic              wb_full;
    logic              wb_empty;
    logic              wb_push;
    logic              wb_pop;
    // st_done: the held store in MEM was already enqueued; do not enqueue it twice
    logic              st_done;
    logic              load_v;
    logic              store_v;

    assign load_v     = acc_valid & ~mem_write;
    assign store_v    = acc_valid & mem_write;
    // Fullness uses the registered count, so a pop never makes room in its own cycle
    assign wb_full    = (wb_count == WB_FULL);
    assign wb_empty   = (wb_count == '0);
    assign wb_push    = store_v & ~st_done & ~wb_full;
    assign wb_pop     = (state == REQ) & ~own_q & bus.data_addr_ok;
    // Buffered stores go first; a load waits until the buffer is empty and the bus is idle
    assign start_buf  = (state == IDLE) & ~wb_empty;
    assign start_own  = (state == IDLE) & wb_empty & load_v;
    assign issue_wait = load_v | (store_v & ~st_done & wb_full);

    // Select the next transaction's fields: buffer head or the load in MEM
    always_comb begin
        st_wr    = mem_write;
        st_size  = req_size;
        st_addr  = mem_addr;
        st_wdata = req_wdata;
        if (start_buf) begin
            st_wr    = 1'b1;
            st_size  = wb_size[wb_head];
            st_addr  = wb_addr[wb_head];
            st_wdata = wb_data[wb_head];
        end
    end

    // Write buffer: enqueue posted stores, pop the head when its request is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_head  <= '0;
            wb_tail  <= '0;
            wb_count <= '0;
            st_done  <= 1'b0;
        end else begin
            if (wb_push) begin
                wb_addr[wb_tail] <= mem_addr;
                wb_size[wb_tail] <= req_size;
                wb_data[wb_tail] <= req_wdata;
                wb_tail          <= wb_tail + 1'b1;
            end
            if (wb_pop) begin
                wb_head <= wb_head + 1'b1;
            end
            wb_count <= wb_count + (PTR_W + 1)'(wb_push) - (PTR_W + 1)'(wb_pop);
            st_done  <= hold & (st_done | wb_push);
        end
    end
`else
    assign start_buf  = 1'b0;
    assign start_own  = (state == IDLE) & acc_valid;
    assign issue_wait = acc_valid;

    // Every transaction comes straight from the instruction in MEM
    always_comb begin
        st_wr    = mem_write;
        st_size  = req_size;
        st_addr  = mem_addr;
        st_wdata = req_wdata;
    end
`endif

    // Stall while the MEM instruction's own access is in flight or still waiting to issue
    always_comb begin
        if (((state == REQ) || (state == RESP)) && own_q) begin
            stall = ~xfer_done;
        end else if (state == DONE) begin
            stall = 1'b0;
        end else begin
            stall = issue_wait;
        end
    end

    // Bus transaction FSM: one outstanding request, outputs registered and held until addr_ok
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_q     <= 1'b0;
            wr_q      <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            zext_q    <= 1'b0;
            own_q     <= 1'b0;
            discard_q <= 1'b0;
            load_q    <= 32'd0;
        end else begin
            if (resp_take) begin
                load_q <= ext_data;
            end
            case (state)
                IDLE: begin
                    if (start_own || start_buf) begin
                        state     <= REQ;
                        req_q     <= 1'b1;
                        wr_q      <= st_wr;
                        size_q    <= st_size;
                        addr_q    <= st_addr;
                        wdata_q   <= st_wdata;
                        zext_q    <= mem_type[2];
                        own_q     <= start_own;
                        discard_q <= 1'b0;
                    end
                end
                REQ: begin
                    if (kill && own_q) begin
                        discard_q <= 1'b1;
                    end
                    if (bus.data_addr_ok) begin
                        req_q <= 1'b0;
                        if (bus.data_data_ok) begin
                            state <= (own_q && hold) ? DONE : IDLE;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (kill && own_q) begin
                        discard_q <= 1'b1;
                    end
                    if (bus.data_data_ok) begin
                        state <= (own_q && hold) ? DONE : IDLE;
                    end
                end
                DONE: begin
                    if (!hold) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_req   = req_q;
    assign bus.data_wr    = wr_q;
    assign bus.data_size  = size_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit (write-buffer case under MAU_WBUF_EN)
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_type;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        kill;
    logic        hold;
    logic [31:0] load_data;
    logic        addr_err;
    logic        stall;

    int n_checks = 0;
    int n_errors = 0;
    int n_req    = 0;

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(
        .ADDR_W     (32),
        .WBUF_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_type  (mem_type),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .kill      (kill),
        .hold      (hold),
        .load_data (load_data),
        .addr_err  (addr_err),
        .stall     (stall),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && bus.data_req && bus.data_addr_ok) begin
            n_req <= n_req + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bus(input string tag, input logic wr, input logic [1:0] sz,
                             input logic [31:0] addr, input logic [31:0] wd);
        check({tag, "_req"},   32'(bus.data_req),  32'd1);
        check({tag, "_wr"},    32'(bus.data_wr),   32'(wr));
        check({tag, "_size"},  32'(bus.data_size), 32'(sz));
        check({tag, "_addr"},  bus.data_addr,      addr);
        check({tag, "_wdata"}, bus.data_wdata,     wd);
    endtask

    // kill_ph: 0 none, 1 from the first REQ cycle on, 2 only once in RESP
    task automatic run_access(input string tag, input logic rd, input logic wr, input logic [2:0] typ,
                              input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                              input int a_lat, input int d_lat, input logic hld, input int kill_ph,
                              input logic [1:0] e_size, input logic [31:0] e_wdata, input logic [31:0] e_ld);
        int req0;
        req0      = n_req;
        mem_read  = rd;
        mem_write = wr;
        mem_type  = typ;
        mem_addr  = addr;
        mem_wdata = wd;
        hold      = hld;
        kill      = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        #1;
        check({tag, "_issue_stall"}, 32'(stall), 32'd1);
        for (int i = 0; i < a_lat; i++) begin
            step();
            kill = (kill_ph == 1);
            #1;
            check_bus({tag, "_wait"}, wr, e_size, addr, e_wdata);
            check({tag, "_wait_stall"}, 32'(stall), 32'd1);
        end
        step();
        kill = (kill_ph == 1);
        bus.data_addr_ok = 1'b1;
        bus.data_data_ok = (d_lat == 0);
        bus.data_rdata   = rdat;
        #1;
        check_bus({tag, "_aok"}, wr, e_size, addr, e_wdata);
        check({tag, "_aok_stall"}, 32'(stall), 32'(d_lat != 0));
        if (d_lat == 0) begin
            check({tag, "_ld"}, load_data, e_ld);
        end
        for (int j = 1; j <= d_lat; j++) begin
            step();
            bus.data_addr_ok = 1'b0;
            kill = (kill_ph != 0);
            bus.data_data_ok = (j == d_lat);
            #1;
            check({tag, "_resp_req"}, 32'(bus.data_req), 32'd0);
            check({tag, "_resp_stall"}, 32'(stall), 32'(j != d_lat));
            if (j == d_lat) begin
                check({tag, "_ld"}, load_data, e_ld);
            end
        end
        step();
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        kill = 1'b0;
        if (hld) begin
            for (int k = 0; k < 2; k++) begin
                #1;
                check({tag, "_done_stall"}, 32'(stall), 32'd0);
                check({tag, "_done_req"}, 32'(bus.data_req), 32'd0);
                step();
            end
            hold = 1'b0;
            step();
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        #1;
        check({tag, "_ld_held"}, load_data, e_ld);
        check({tag, "_nreq"}, 32'(n_req - req0), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_type  = 3'b000;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        kill      = 1'b0;
        hold      = 1'b0;
        bus.data_rdata   = 32'd0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        step();
        step();
        check("rst_req",   32'(bus.data_req),  32'd0);
        check("rst_wr",    32'(bus.data_wr),   32'd0);
        check("rst_size",  32'(bus.data_size), 32'd0);
        check("rst_addr",  bus.data_addr,      32'd0);
        check("rst_wdata", bus.data_wdata,     32'd0);
        check("rst_stall", 32'(stall),         32'd0);
        check("rst_ld",    load_data,          32'd0);
        rst = 1'b0;
        step();

        // Byte loads, signed then unsigned
        run_access("lb",  1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF7F, 0, 0, 0, 0, 2'd0, 32'h0, 32'hFFFF_FF80);
        step();
        run_access("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_FF7F, 1, 0, 0, 0, 2'd0, 32'h0, 32'h0000_0080);
        step();

`ifndef MAU_WBUF_EN
        // Stores stall until data_ok; data replicated to all lanes
        run_access("sh", 0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 1, 1, 0, 0, 2'd1, 32'hABCD_ABCD, 32'h0000_0080);
        step();
        run_access("sb", 0, 1, 3'b000, 32'h201, 32'h0000_00EE, 32'h0, 0, 1, 0, 0, 2'd0, 32'hEEEE_EEEE, 32'h0000_0080);
        step();
`endif

        // Misaligned and killed accesses never reach the bus
        begin
            int req0;
            req0      = n_req;
            mem_read  = 1'b1;
            mem_type  = 3'b010;
            mem_addr  = 32'h101;
            #1;
            check("lw_mis_err",   32'(addr_err), 32'd1);
            check("lw_mis_stall", 32'(stall),    32'd0);
            step();
            check("lw_mis_req",   32'(bus.data_req), 32'd0);
            mem_type  = 3'b001;
            mem_addr  = 32'h103;
            #1;
            check("lh_mis_err",   32'(addr_err), 32'd1);
            step();
            mem_addr  = 32'h102;
            kill      = 1'b1;
            #1;
            check("lh_ok_err",    32'(addr_err), 32'd0);
            check("lh_kill_stall", 32'(stall),   32'd0);
            step();
            check("lh_kill_req",  32'(bus.data_req), 32'd0);
            kill      = 1'b0;
            mem_read  = 1'b0;
            step();
            check("mis_nreq", 32'(n_req - req0), 32'd0);
        end

        // Delayed handshakes, same-cycle handshake under hold, signed half
        run_access("lw_slow", 1, 0, 3'b010, 32'h104, 32'h0, 32'hDEAD_BEEF, 3, 2, 0, 0, 2'd2, 32'h0, 32'hDEAD_BEEF);
        step();
        run_access("lhu_hold", 1, 0, 3'b101, 32'h106, 32'h0, 32'h8001_0000, 0, 0, 1, 0, 2'd1, 32'h0, 32'h0000_8001);
        step();
        run_access("lh", 1, 0, 3'b001, 32'h10A, 32'h0, 32'h8765_1234, 1, 1, 0, 0, 2'd1, 32'h0, 32'hFFFF_8765);
        step();

        // Killed after issue: transaction completes, result discarded
        run_access("kill_resp", 1, 0, 3'b010, 32'h108, 32'h0, 32'h5555_5555, 1, 2, 0, 2, 2'd2, 32'h0, 32'hFFFF_8765);
        step();
        run_access("kill_req", 1, 0, 3'b000, 32'h10C, 32'h0, 32'hAAAA_AAAA, 2, 1, 0, 1, 2'd0, 32'h0, 32'hFFFF_8765);
        step();
        run_access("lb_lane1", 1, 0, 3'b000, 32'h10D, 32'h0, 32'h0000_7F00, 0, 1, 0, 0, 2'd0, 32'h0, 32'h0000_007F);
        step();

        // Reset in the middle of a transaction
        mem_read = 1'b1;
        mem_type = 3'b010;
        mem_addr = 32'h110;
        step();
        check("mid_req", 32'(bus.data_req), 32'd1);
        rst      = 1'b1;
        mem_read = 1'b0;
        step();
        check("mid_rst_req",   32'(bus.data_req), 32'd0);
        check("mid_rst_addr",  bus.data_addr,     32'd0);
        check("mid_rst_ld",    load_data,         32'd0);
        check("mid_rst_stall", 32'(stall),        32'd0);
        rst = 1'b0;
        step();

`ifdef MAU_WBUF_EN
        // Five back-to-back SW into a 4-entry buffer, then a strictly ordered LW
        begin
            logic [31:0] exp_addr;
            int          writes_done;
            logic        pend;
            logic        cur_wr;
            logic        ld_done;
            mem_write = 1'b1;
            mem_type  = 3'b010;
            for (int k = 0; k < 4; k++) begin
                mem_addr  = 32'h300 + 32'(4 * k);
                mem_wdata = 32'(k);
                #1;
                check("wb_accept_stall", 32'(stall), 32'd0);
                step();
            end
            mem_addr  = 32'h310;
            mem_wdata = 32'd4;
            #1;
            check("wb_full_stall0", 32'(stall), 32'd1);
            step();
            check("wb_head_addr", bus.data_addr, 32'h300);
            check("wb_full_stall1", 32'(stall), 32'd1);
            step();
            bus.data_addr_ok = 1'b1;
            #1;
            check("wb_pop_stall", 32'(stall), 32'd1);
            step();
            bus.data_addr_ok = 1'b0;
            #1;
            check("wb_free_stall", 32'(stall), 32'd0);
            step();
            mem_write   = 1'b0;
            mem_read    = 1'b1;
            mem_addr    = 32'h400;
            exp_addr    = 32'h304;
            writes_done = 0;
            pend        = 1'b1;
            cur_wr      = 1'b1;
            ld_done     = 1'b0;
            bus.data_rdata = 32'h1234_5678;
            for (int c = 0; c < 60 && !ld_done; c++) begin
                bus.data_data_ok = pend;
                bus.data_addr_ok = bus.data_req;
                #1;
                if (bus.data_data_ok) begin
                    if (cur_wr) begin
                        writes_done++;
                    end else begin
                        check("wb_ld_data", load_data, 32'h1234_5678);
                        check("wb_ld_stall", 32'(stall), 32'd0);
                        ld_done = 1'b1;
                    end
                end else begin
                    check("wb_ld_wait_stall", 32'(stall), 32'd1);
                end
                if (bus.data_addr_ok) begin
                    cur_wr = bus.data_wr;
                    if (bus.data_wr) begin
                        check("wb_order_addr", bus.data_addr, exp_addr);
                        exp_addr = exp_addr + 32'd4;
                    end else begin
                        check("wb_ld_after_writes", 32'(writes_done), 32'd5);
                        check("wb_ld_addr", bus.data_addr, 32'h400);
                    end
                end
                pend = bus.data_addr_ok;
                step();
            end
            check("wb_ld_complete", 32'(ld_done), 32'd1);
            mem_read = 1'b0;
            bus.data_addr_ok = 1'b0;
            bus.data_data_ok = 1'b0;
            step();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
